// File: rtl/mem_transfer_unit_if.sv
// -----------------------------------------------------------------------------
// mem_transfer_unit_if
// Purpose : bundles the controller strobes and the datapath results exchanged
//           between the access controller (master) and mem_transfer_unit
//           (slave). Clock and reset are plain ports on the modules.
// Signals :
//   Active, SampleData, AccessMem, RWMem, TransferData  master -> slave strobes
//   AddrIn [ADDR_WIDTH], DataIn [DATA_WIDTH]            master -> slave operands
//   SerialOut, SerialValid, TransferDone, XferBusy,
//   CmdError, DataOut [DATA_WIDTH]                      slave -> master results
//   dbg_state [2]                                       slave FSM state (debug)
//
// Handshake: there is no backpressure. A strobe is a level sampled at every
// rising clock edge; it either executes at that edge or is dropped, and a
// dropped strobe (while Active=1) is reported by a one-cycle CmdError pulse.
// SerialValid qualifies SerialOut bit-by-bit; the receiver must take the bit
// in every cycle SerialValid is high.
// -----------------------------------------------------------------------------
interface mem_transfer_unit_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  Active;
    logic                  SampleData;
    logic                  AccessMem;
    logic                  RWMem;
    logic                  TransferData;
    logic [ADDR_WIDTH-1:0] AddrIn;
    logic [DATA_WIDTH-1:0] DataIn;

    logic                  SerialOut;
    logic                  SerialValid;
    logic                  TransferDone;
    logic                  XferBusy;
    logic                  CmdError;
    logic [DATA_WIDTH-1:0] DataOut;
    logic [1:0]            dbg_state;

    modport master (
        output Active, SampleData, AccessMem, RWMem, TransferData, AddrIn, DataIn,
        input  SerialOut, SerialValid, TransferDone, XferBusy, CmdError, DataOut,
        input  dbg_state
    );

    modport slave (
        input  Active, SampleData, AccessMem, RWMem, TransferData, AddrIn, DataIn,
        output SerialOut, SerialValid, TransferDone, XferBusy, CmdError, DataOut,
        output dbg_state
    );
endinterface

// File: rtl/mem_transfer_unit.sv
// -----------------------------------------------------------------------------
// mem_transfer_unit
// Purpose : datapath stage behind the access controller. Holds an address and
//           data register plus a small register-file memory, executes the
//           controller strobes, and serialises the data register MSB first,
//           closing each transfer with a one-cycle TransferDone pulse.
// Ports   :
//   Clk    in  rising-edge clock
//   Reset  in  synchronous, active-high; clears every register and memory word
//   bus    mem_transfer_unit_if.slave (strobes in, serial/status/data out)
// -----------------------------------------------------------------------------
module mem_transfer_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    mem_transfer_unit_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic                  r_cmd_error;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_any_strobe;
    logic                  w_shifting;

    always_comb begin
        w_any_strobe = bus.SampleData | bus.AccessMem | bus.TransferData;
        w_shifting   = (r_state == ST_SHIFT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_cmd_error <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_cmd_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.Active) begin
                        // Fixed priority; whatever loses is dropped and flagged.
                        if (bus.SampleData) begin
                            r_addr      <= bus.AddrIn;
                            r_data      <= bus.DataIn;
                            r_cmd_error <= bus.AccessMem | bus.TransferData;
                        end else if (bus.AccessMem) begin
                            // Uses r_addr/r_data as held before this edge.
                            if (bus.RWMem) begin
                                r_mem[r_addr] <= r_data;
                            end else begin
                                r_data <= r_mem[r_addr];
                            end
                            r_cmd_error <= bus.TransferData;
                        end else if (bus.TransferData) begin
                            // Separate shift copy so DataOut stays stable.
                            r_shift <= r_data;
                            r_cnt   <= CW'(DATA_WIDTH);
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!bus.Active) begin
                        // Abort: no TransferDone for a cut-short transfer.
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cmd_error <= w_any_strobe;
                        r_shift     <= {r_shift[DATA_WIDTH-2:0], 1'b0};
                        // r_cnt counts bits still to present, including this one.
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                        if (r_cnt <= CW'(1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_cmd_error <= bus.Active & w_any_strobe;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.SerialValid  = w_shifting;
        bus.SerialOut    = w_shifting & r_shift[DATA_WIDTH-1];
        bus.XferBusy     = w_shifting;
        bus.TransferDone = (r_state == ST_DONE);
        bus.CmdError     = r_cmd_error;
        bus.DataOut      = r_data;
        bus.dbg_state    = r_state;
    end
endmodule

// File: tb/tb_mem_transfer_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_transfer_unit
// Purpose : self-checking bench for mem_transfer_unit. A behavioural model
//           (address/data variables, a memory array and a queue of pending
//           serial bits) predicts every output after every clock edge.
// -----------------------------------------------------------------------------
module tb_mem_transfer_unit;
    localparam int DW = 8;
    localparam int AW = 4;

    logic clk;
    logic rst;

    mem_transfer_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_transfer_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_mem [2**AW];
    logic [0:0]    exp_q [$];     // serial bits still to appear, MSB first
    logic          m_done;
    logic          m_err;

    int    cnt_total;
    int    cnt_bad;
    string phase;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cnt_total++;
        if (obs !== exp) begin
            cnt_bad++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task model_edge();
        logic any_s;
        logic was_busy;
        any_s    = bus.SampleData | bus.AccessMem | bus.TransferData;
        was_busy = (exp_q.size() > 0);
        if (rst) begin
            m_addr = '0;
            m_data = '0;
            for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
            exp_q.delete();
            m_done = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_err = 1'b0;
            if (was_busy) begin
                m_done = 1'b0;
                if (!bus.Active) begin
                    exp_q.delete();
                end else begin
                    m_err = any_s;
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) m_done = 1'b1;
                end
            end else if (m_done) begin
                m_done = 1'b0;
                m_err  = bus.Active & any_s;
            end else if (bus.Active) begin
                if (bus.SampleData) begin
                    m_addr = bus.AddrIn;
                    m_data = bus.DataIn;
                    m_err  = bus.AccessMem | bus.TransferData;
                end else if (bus.AccessMem) begin
                    if (bus.RWMem) m_mem[m_addr] = m_data;
                    else           m_data = m_mem[m_addr];
                    m_err = bus.TransferData;
                end else if (bus.TransferData) begin
                    for (int i = DW - 1; i >= 0; i--) exp_q.push_back(m_data[i]);
                end
            end
        end
    endtask

    task compare_outputs();
        logic       busy;
        logic [0:0] bit_e;
        busy  = (exp_q.size() > 0);
        bit_e = busy ? exp_q[0] : 1'b0;
        check("serial_valid",  32'(bus.SerialValid),  32'(busy));
        check("serial_out",    32'(bus.SerialOut),    32'(bit_e));
        check("xfer_busy",     32'(bus.XferBusy),     32'(busy));
        check("transfer_done", 32'(bus.TransferDone), 32'(m_done));
        check("cmd_error",     32'(bus.CmdError),     32'(m_err));
        check("data_out",      32'(bus.DataOut),      32'(m_data));
    endtask

    // ---------------- driver tasks ----------------
    task step();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task clear_strobes();
        bus.SampleData   = 1'b0;
        bus.AccessMem    = 1'b0;
        bus.RWMem        = 1'b0;
        bus.TransferData = 1'b0;
    endtask

    task idle_cycles(input int n);
        clear_strobes();
        for (int i = 0; i < n; i++) step();
    endtask

    task pulse(input logic sd, input logic am, input logic rw, input logic td,
               input logic [AW-1:0] ai, input logic [DW-1:0] di);
        bus.SampleData   = sd;
        bus.AccessMem    = am;
        bus.RWMem        = rw;
        bus.TransferData = td;
        bus.AddrIn       = ai;
        bus.DataIn       = di;
        step();
        clear_strobes();
    endtask

    task do_reset();
        clear_strobes();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [DW-1:0] obs_byte;

    initial begin
        cnt_total  = 0;
        cnt_bad    = 0;
        phase      = "reset";
        rst        = 1'b1;
        bus.Active = 1'b1;
        bus.AddrIn = '0;
        bus.DataIn = '0;
        clear_strobes();
        m_addr = '0;
        m_data = '0;
        m_done = 1'b0;
        m_err  = 1'b0;
        for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
        step();
        step();
        rst = 1'b0;
        idle_cycles(2);

        // 1: write A5 to addr 3, clobber DataReg, read it back
        phase = "t1";
        pulse(1, 0, 0, 0, 4'd3, 8'hA5);
        pulse(0, 1, 1, 0, 4'd0, 8'h00);
        pulse(1, 0, 0, 0, 4'd3, 8'h00);
        pulse(0, 1, 0, 0, 4'd0, 8'h00);
        check("readback", 32'(bus.DataOut), 32'h0000_00A5);
        idle_cycles(1);

        // 2: serialise A5, collect bits from SerialOut
        phase = "t2";
        pulse(0, 0, 0, 1, 4'd0, 8'h00);
        obs_byte = '0;
        for (int i = 0; i < DW; i++) begin
            obs_byte = {obs_byte[DW-2:0], bus.SerialOut};
            step();
        end
        check("stream", 32'(obs_byte), 32'h0000_00A5);
        check("done_pulse", 32'(bus.TransferDone), 32'd1);
        check("busy_after", 32'(bus.XferBusy), 32'd0);
        idle_cycles(2);

        // 3: strobes during SHIFT are dropped with CmdError
        phase = "t3";
        pulse(0, 0, 0, 1, 4'd0, 8'h00);
        pulse(1, 0, 0, 0, 4'd5, 8'h3C);
        check("err_sd", 32'(bus.CmdError), 32'd1);
        pulse(0, 1, 1, 0, 4'd0, 8'h00);
        pulse(0, 0, 0, 1, 4'd0, 8'h00);
        idle_cycles(DW);
        pulse(0, 1, 0, 0, 4'd0, 8'h00);
        check("mem_kept", 32'(bus.DataOut), 32'h0000_00A5);
        idle_cycles(1);

        // 4: Active drop mid-transfer aborts; strobe with Active=0 is ignored
        phase = "t4";
        pulse(0, 0, 0, 1, 4'd0, 8'h00);
        idle_cycles(3);
        bus.Active = 1'b0;
        step();
        check("abort_valid", 32'(bus.SerialValid), 32'd0);
        idle_cycles(DW);
        pulse(1, 1, 1, 1, 4'd9, 8'h77);
        check("inactive_err", 32'(bus.CmdError), 32'd0);
        bus.Active = 1'b1;
        idle_cycles(2);

        // 5: SampleData beats AccessMem write in the same cycle
        phase = "t5";
        pulse(1, 1, 1, 0, 4'd7, 8'h5A);
        check("conflict_err", 32'(bus.CmdError), 32'd1);
        pulse(0, 1, 0, 0, 4'd0, 8'h00);
        check("mem_unwritten", 32'(bus.DataOut), 32'd0);
        idle_cycles(1);

        // 6: reset mid-transfer, then a clean transfer
        phase = "t6";
        pulse(1, 0, 0, 0, 4'd2, 8'hC3);
        pulse(0, 0, 0, 1, 4'd0, 8'h00);
        idle_cycles(2);
        do_reset();
        check("rst_valid", 32'(bus.SerialValid), 32'd0);
        check("rst_data",  32'(bus.DataOut), 32'd0);
        pulse(0, 1, 0, 0, 4'd0, 8'h00);
        pulse(1, 0, 0, 0, 4'd1, 8'h96);
        pulse(0, 0, 0, 1, 4'd0, 8'h00);
        idle_cycles(DW + 2);

        // random traffic against the model
        phase = "rand";
        for (int n = 0; n < 600; n++) begin
            rst              = ($urandom_range(0, 99) < 2);
            bus.Active       = ($urandom_range(0, 99) < 92);
            bus.SampleData   = ($urandom_range(0, 99) < 15);
            bus.AccessMem    = ($urandom_range(0, 99) < 20);
            bus.RWMem        = 1'($urandom_range(0, 1));
            bus.TransferData = ($urandom_range(0, 99) < 15);
            bus.AddrIn       = AW'($urandom_range(0, 2**AW - 1));
            bus.DataIn       = DW'($urandom);
            step();
        end
        rst        = 1'b0;
        bus.Active = 1'b1;
        idle_cycles(DW + 2);

        $display("test done: total=%0d bad=%0d", cnt_total, cnt_bad);
        $finish;
    end
endmodule
